// File: rtl/mux_pkg.sv
// Shared sizing helpers for the pipelined wide-mux family.
package mux_pkg;

    // Number of register stages needed to cover l tree levels at lps levels each.
    function automatic int mux_stages(int l, int lps);
        return (l + lps - 1) / lps;
    endfunction

    // Entry count of the full radix-2 tree that covers w inputs.
    function automatic int mux_pad_width(int w);
        return 1 << $clog2(w);
    endfunction

endpackage

// File: rtl/mux_tree_levels.sv
// Combinational slice of a radix-2 mux tree: ENTRIES inputs reduced by LEVELS select bits.
module mux_tree_levels #(
    parameter int unsigned LEVELS  = 2,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned WIDTH   = 64
) (
    input  logic [ENTRIES-1:0][WIDTH-1:0]             data_i,
    input  logic [LEVELS-1:0]                         sel_i,
    output logic [(ENTRIES >> LEVELS)-1:0][WIDTH-1:0] data_o
);

    // Level j holds ENTRIES >> j nodes; node i picks between children 2i and 2i+1.
    for (genvar j = 0; j <= LEVELS; j++) begin : g_lvl
        localparam int unsigned N = ENTRIES >> j;
        logic [N-1:0][WIDTH-1:0] node;

        if (j == 0) begin : g_leaf
            assign node = data_i;
        end else begin : g_inner
            for (genvar i = 0; i < N; i++) begin : g_node
                assign node[i] = sel_i[j-1] ? g_lvl[j-1].node[2*i+1]
                                            : g_lvl[j-1].node[2*i];
            end
        end
    end

    assign data_o = g_lvl[LEVELS].node;

endmodule

// File: rtl/mux_nxmx1_pipe.sv
// Pipelined N-bit M-to-1 mux with valid/ready handshake; the tree is cut by a register
// bank every LEVELS_PER_STAGE levels, and select bits and tag ride along with the data.
module mux_nxmx1_pipe
    import mux_pkg::*;
#(
    parameter int unsigned INPUT_LENGTH     = 64,
    parameter int unsigned INPUT_WIDTH      = 16,
    parameter int unsigned SELECT_WIDTH     = $clog2(INPUT_WIDTH),
    parameter int unsigned LEVELS_PER_STAGE = 2,
    parameter int unsigned TAG_WIDTH        = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [INPUT_WIDTH-1:0][INPUT_LENGTH-1:0] inputs_i,
    input  logic [SELECT_WIDTH-1:0]                 selects_i,
    input  logic [TAG_WIDTH-1:0]                    tag_i,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    output logic [INPUT_LENGTH-1:0]                 outputs_o,
    output logic [TAG_WIDTH-1:0]                    tag_o,
    output logic                                    valid_o,
    input  logic                                    ready_i
);

    localparam int unsigned L   = SELECT_WIDTH;
    localparam int unsigned PAD = mux_pad_width(INPUT_WIDTH);
    localparam int unsigned S   = mux_stages(L, LEVELS_PER_STAGE);

    logic                             advance_c;
    logic [PAD-1:0][INPUT_LENGTH-1:0] padded_c;

    // Missing tree leaves read as zero, which is what an out-of-range select returns.
    if (PAD > INPUT_WIDTH) begin : g_pad
        assign padded_c = {{((PAD - INPUT_WIDTH) * INPUT_LENGTH){1'b0}}, inputs_i};
    end else begin : g_nopad
        assign padded_c = inputs_i;
    end

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int unsigned LO    = s * LEVELS_PER_STAGE;
        localparam int unsigned LVL   = ((L - LO) < LEVELS_PER_STAGE) ? (L - LO) : LEVELS_PER_STAGE;
        localparam int unsigned N_IN  = PAD >> LO;
        localparam int unsigned N_OUT = N_IN >> LVL;
        localparam int unsigned REM   = L - LO - LVL;

        logic [N_IN-1:0][INPUT_LENGTH-1:0]  data_in_c;
        logic [L-LO-1:0]                    sel_in_c;
        logic [TAG_WIDTH-1:0]               tag_in_c;
        logic                               valid_in_c;
        logic [N_OUT-1:0][INPUT_LENGTH-1:0] data_d;
        logic [N_OUT-1:0][INPUT_LENGTH-1:0] data_q;
        logic [TAG_WIDTH-1:0]               tag_q;
        logic                               valid_q;

        if (s == 0) begin : g_src_in
            assign data_in_c  = padded_c;
            assign sel_in_c   = selects_i;
            assign tag_in_c   = tag_i;
            assign valid_in_c = valid_i;
        end else begin : g_src_prev
            assign data_in_c  = g_stage[s-1].data_q;
            assign sel_in_c   = g_stage[s-1].g_sel.sel_q;
            assign tag_in_c   = g_stage[s-1].tag_q;
            assign valid_in_c = g_stage[s-1].valid_q;
        end

        mux_tree_levels #(
            .LEVELS  (LVL),
            .ENTRIES (N_IN),
            .WIDTH   (INPUT_LENGTH)
        ) u_tree (
            .data_i (data_in_c),
            .sel_i  (sel_in_c[LVL-1:0]),
            .data_o (data_d)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
            end else if (advance_c) begin
                valid_q <= valid_in_c;
            end
        end

        // Payload only toggles for real beats; bubbles leave it untouched.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q <= '0;
                tag_q  <= '0;
            end else if (advance_c && valid_in_c) begin
                data_q <= data_d;
                tag_q  <= tag_in_c;
            end
        end

        if (REM > 0) begin : g_sel
            logic [REM-1:0] sel_d;
            logic [REM-1:0] sel_q;

            assign sel_d = sel_in_c[L-LO-1:LVL];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sel_q <= '0;
                end else if (advance_c && valid_in_c) begin
                    sel_q <= sel_d;
                end
            end
        end
    end

    assign valid_o   = g_stage[S-1].valid_q;
    assign outputs_o = g_stage[S-1].data_q[0];
    assign tag_o     = g_stage[S-1].tag_q;

    // Whole pipe moves in lockstep whenever the output slot can be vacated or is empty.
    assign advance_c = ready_i | ~valid_o;
    assign ready_o   = advance_c;

endmodule

// File: tb/tb_mux_nxmx1_pipe.sv
// Randomized bench for three mux_nxmx1_pipe configurations against a slot-queue reference model.
module tb_mux_nxmx1_pipe;

    logic clk;
    logic rst_n;
    logic valid_i;
    logic ready_i;
    logic [3:0] tag_i;

    logic [15:0][63:0] in0;
    logic [3:0]        sel0;
    logic [63:0]       out0;
    logic [3:0]        tag0;
    logic              vo0, ro0;

    logic [4:0][63:0]  in1;
    logic [2:0]        sel1;
    logic [63:0]       out1;
    logic [3:0]        tag1;
    logic              vo1, ro1;

    logic [1:0][0:0]   in2;
    logic [0:0]        sel2;
    logic [0:0]        out2;
    logic [3:0]        tag2;
    logic              vo2, ro2;

    int checks = 0;
    int errors = 0;

    // Reference: per-config row of latency slots; slot S-1 is what the output must show.
    int          sk[3];
    logic        mv[3][3];
    logic [63:0] md[3][3];
    logic [3:0]  mt[3][3];

    mux_nxmx1_pipe #(.INPUT_LENGTH(64), .INPUT_WIDTH(16), .SELECT_WIDTH(4),
                     .LEVELS_PER_STAGE(2), .TAG_WIDTH(4)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .inputs_i(in0), .selects_i(sel0), .tag_i(tag_i),
        .valid_i(valid_i), .ready_o(ro0), .outputs_o(out0), .tag_o(tag0),
        .valid_o(vo0), .ready_i(ready_i));

    mux_nxmx1_pipe #(.INPUT_LENGTH(64), .INPUT_WIDTH(5), .SELECT_WIDTH(3),
                     .LEVELS_PER_STAGE(1), .TAG_WIDTH(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .inputs_i(in1), .selects_i(sel1), .tag_i(tag_i),
        .valid_i(valid_i), .ready_o(ro1), .outputs_o(out1), .tag_o(tag1),
        .valid_o(vo1), .ready_i(ready_i));

    mux_nxmx1_pipe #(.INPUT_LENGTH(1), .INPUT_WIDTH(2), .SELECT_WIDTH(1),
                     .LEVELS_PER_STAGE(1), .TAG_WIDTH(4)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .inputs_i(in2), .selects_i(sel2), .tag_i(tag_i),
        .valid_i(valid_i), .ready_o(ro2), .outputs_o(out2), .tag_o(tag2),
        .valid_o(vo2), .ready_i(ready_i));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_data(input int k);
        case (k)
            0:       return in0[sel0];
            1:       return (sel1 < 3'd5) ? in1[sel1] : 64'd0;
            default: return 64'(in2[sel2]);
        endcase
    endfunction

    task automatic drive(input int cyc);
        ready_i = 1'b1;
        valid_i = 1'b1;
        tag_i   = 4'(cyc);
        sel0    = 4'($urandom);
        sel1    = 3'($urandom);
        sel2    = 1'($urandom);
        for (int i = 0; i < 16; i++) in0[4'(i)] = {$urandom, $urandom};
        for (int i = 0; i < 5; i++)  in1[3'(i)] = {$urandom, $urandom};
        in2 = 2'($urandom);
        if (cyc < 20) begin
            // Directed sweep of every select with an index-tagged pattern.
            sel0 = 4'(cyc);
            sel1 = 3'(cyc);
            sel2 = 1'(cyc);
            for (int i = 0; i < 16; i++) in0[4'(i)] = 64'h1111_0000_0000_0000 + 64'(i);
        end else if (cyc >= 200 && cyc < 212) begin
            valid_i = (cyc < 208);
            tag_i   = 4'(cyc - 200);
            ready_i = !(cyc >= 203 && cyc < 206);
        end else if (cyc >= 212 && cyc < 240) begin
            valid_i = 1'((cyc + 1) % 2);
            ready_i = ((cyc % 5) != 0);
        end else if (cyc >= 296 && cyc <= 300) begin
            valid_i = 1'b1;
        end else begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic step(input int cyc);
        logic [63:0] got_d[3];
        logic [3:0]  got_t[3];
        logic        got_v[3];
        logic        got_r[3];
        logic        adv;
        drive(cyc);
        #1;
        got_d[0] = out0; got_d[1] = out1; got_d[2] = 64'(out2);
        got_t[0] = tag0; got_t[1] = tag1; got_t[2] = tag2;
        got_v[0] = vo0;  got_v[1] = vo1;  got_v[2] = vo2;
        got_r[0] = ro0;  got_r[1] = ro1;  got_r[2] = ro2;
        for (int k = 0; k < 3; k++) begin
            adv = ready_i | ~mv[k][sk[k]-1];
            check($sformatf("c%0d_d%0d_ready", cyc, k), 64'(got_r[k]), 64'(adv));
            check($sformatf("c%0d_d%0d_valid", cyc, k), 64'(got_v[k]), 64'(mv[k][sk[k]-1]));
            if (mv[k][sk[k]-1]) begin
                check($sformatf("c%0d_d%0d_data", cyc, k), got_d[k], md[k][sk[k]-1]);
                check($sformatf("c%0d_d%0d_tag", cyc, k), 64'(got_t[k]), 64'(mt[k][sk[k]-1]));
            end
            if (adv) begin
                for (int j = sk[k] - 1; j > 0; j--) begin
                    mv[k][j] = mv[k][j-1];
                    md[k][j] = md[k][j-1];
                    mt[k][j] = mt[k][j-1];
                end
                mv[k][0] = valid_i;
                md[k][0] = ref_data(k);
                mt[k][0] = tag_i;
            end
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_d0_valid"}, 64'(vo0), 64'd0);
        check({name, "_d1_valid"}, 64'(vo1), 64'd0);
        check({name, "_d2_valid"}, 64'(vo2), 64'd0);
        check({name, "_d0_data"}, out0, 64'd0);
        check({name, "_d1_data"}, out1, 64'd0);
        check({name, "_d0_tag"}, 64'(tag0), 64'd0);
        check({name, "_d0_ready"}, 64'(ro0), 64'd1);
        check({name, "_d1_ready"}, 64'(ro1), 64'd1);
        check({name, "_d2_ready"}, 64'(ro2), 64'd1);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) mv[k][j] = 1'b0;
    endtask

    initial begin
        sk[0] = 2; sk[1] = 3; sk[2] = 1;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) begin
                mv[k][j] = 1'b0;
                md[k][j] = '0;
                mt[k][j] = '0;
            end
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        tag_i   = '0;
        in0 = '0; in1 = '0; in2 = '0;
        sel0 = '0; sel1 = '0; sel2 = '0;
        #3;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            step(cyc);
            if (cyc == 300) begin
                // Asynchronous pulse between edges with beats still in flight.
                @(posedge clk);
                #2;
                rst_n   = 1'b0;
                valid_i = 1'b0;
                #1;
                check_reset_state("midrst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nxmx1_pipe.md
# mux_nxmx1_pipe

Parametrised, pipelined N-bit M-to-1 multiplexer with a valid/ready handshake. It generalises the fixed-size combinational wide muxes to any input count and any pipeline depth. It is used on wide datapath selects, such as register-file read and forwarding paths, where a single-cycle 32- or 64-way mux misses timing. A radix-2 select tree is cut by registers every `LEVELS_PER_STAGE` levels. Select bits and a sideband tag travel with the data.

## Interface
- `INPUT_LENGTH`, 64: bit width of each data input and of the output.
- `INPUT_WIDTH`, 16: number of data inputs. Must be ≥2; need not be a power of two.
- `SELECT_WIDTH`, `$clog2(INPUT_WIDTH)`: select width, equal to the tree depth L.
- `LEVELS_PER_STAGE`, 2: tree levels between pipeline registers. Valid range is 1..L.
- `TAG_WIDTH`, 4: width of the sideband tag carried alongside the data.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `inputs_i`  in  [INPUT_WIDTH-1:0][INPUT_LENGTH-1:0]  data inputs.
- `selects_i`  in  SELECT_WIDTH  index of the input to forward.
- `tag_i`  in  TAG_WIDTH  sideband tag, returned with the result.
- `valid_i`  in  1  input beat valid.
- `ready_o`  out  1  block accepts a beat this cycle.
- `outputs_o`  out  INPUT_LENGTH  selected data.
- `tag_o`  out  TAG_WIDTH  tag of the beat on `outputs_o`.
- `valid_o`  out  1  output beat valid.
- `ready_i`  in  1  consumer accepts the output beat.

## Operation
- **Tree.** Level 0 pairs the inputs using `selects_i[0]`. Level k uses select bit k. Inputs at indices ≥ `INPUT_WIDTH` are tied to zero.
- **Out-of-range select.** A select value ≥ `INPUT_WIDTH` yields all-zero data with `valid_o` still asserted. It is not an error.
- **Stages.** Number of stages S = ceil(L / `LEVELS_PER_STAGE`). A register bank follows each group of levels; the last bank is the output register.
- **Stage contents.** Each bank holds the partial mux results, the unused upper select bits, the tag, and a valid bit.
- **Advance rule.** `advance = ready_i | ~valid_o`.
  - When `advance` = 1, every stage loads from its predecessor; stage 0 loads from the inputs.
  - When `advance` = 0, every stage holds.
  - No bubble collapse.
- **Ready.** `ready_o = advance`, combinational from `ready_i` and `valid_o`.
- **Accept.** A beat is accepted when `valid_i & ready_o`. If `valid_i` = 0 while advancing, a bubble (valid = 0) enters stage 0.
- **Data in bubbles.** The data and tag registers of a bubble stage are don't-care. They are loaded only when the incoming valid = 1, to save power.
- **Hold while stalled.** Output data and tag stay stable while `valid_o & ~ready_i`.
- **Reset.** All valid bits clear immediately on `rst_ni` low. `outputs_o`, `tag_o` and `valid_o` reset to 0. `ready_o` is therefore 1 during reset.
- **Reset mid-stream.** Asserting reset with beats in flight drops them; none reappear after release.

## Timing
- **Latency.** Exactly S cycles from acceptance to `valid_o`, with no stall. Defaults (L = 4, 2 levels/stage): S = 2.
- **Throughput.** One beat per cycle while `ready_i` = 1.
- **Back-to-back.** Consecutive beats emerge on consecutive cycles, in order, each with its own tag.
- **Stall.** `ready_i` low for n cycles with `valid_o` = 1 freezes the pipeline for n cycles. No beats are lost or duplicated. `ready_o` is low during those cycles.
- **Bubble while stalled.** `ready_i` low with `valid_o` = 0 still advances, so interior bubbles drain while the output is empty.
- **Reset release.** First acceptance is possible on the first rising edge after `rst_ni` goes high.

## Structure
- **Package `mux_pkg`:**
  - `function automatic int mux_stages(int l, int lps)` returning ceil(l/lps).
  - Typedef-free helper `mux_pad_width(int w)` returning 2**clog2(w).
  - Both are shared with future mux variants.
- **Sub-module `mux_tree_levels`:** combinational, parametrised by level count and entry count. Reduces 2^k entries to 2^(k-m) entries using m select bits. It is instantiated once per stage inside a generate loop.
- **Top level:** owns the stage registers, the valid chain and the handshake.

## Test plan
1. **Sweep, defaults.** Load `inputs_i[i]` = 64'h1111_0000_0000_0000 + i and sweep select 0..15 with `ready_i` = 1. Each output equals input[sel] with the matching tag exactly 2 cycles later.
2. **Padding and out-of-range.** Use `INPUT_WIDTH` = 5 (L = 3) and `LEVELS_PER_STAGE` = 1, giving S = 3. Select 4 → input[4] after 3 cycles. Select 7 → `outputs_o` = 0 with `valid_o` = 1.
3. **Backpressure.** Stream 8 beats with tags 0..7. Hold `ready_i` low for 3 cycles after the first output. `ready_o` is low for those 3 cycles. All 8 tags appear in order; output data is stable during the stall.
4. **Bubbles.** Alternate `valid_i` 1/0. `valid_o` shows the same alternating pattern delayed by S. Holding `ready_i` low while `valid_o` = 0 still accepts input.
5. **Reset mid-stream.** Pulse `rst_ni` low asynchronously (between edges) with 2 beats in flight. `valid_o` drops to 0 within the same cycle, no stale beat appears afterwards, and the next accepted beat has latency S.
6. **Boundary parameters.** Use `LEVELS_PER_STAGE` = L with `INPUT_LENGTH` = 1 and `INPUT_WIDTH` = 2. Latency is 1 cycle and select 1 → input[1].
